led_seq_ctrl: RTL and testbench

Sequencer for the LED pattern engines. It drives the `en`/`done` handshake of one forward-sweep engine and one backward-sweep engine, and inserts a programmable dwell between passes. It also muxes the active engine's LEDs to the board pins and reports pass count, busy and timeout status. It sits between the top-level button/mode logic and the pattern engines.

---
 rtl/led_seq_ctrl.sv | 145 ++++++++++++++
 tb/tb_led_seq_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/led_seq_ctrl.sv
// Sequencer for the forward/backward LED pattern engines with dwell, timeout and pass counting.
// Define LED_SEQ_PAUSE_EN to add the pause input that freezes the dwell between passes.
module led_seq_ctrl #(
    parameter int DWELL   = 8,
    parameter int TIMEOUT = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       stop,
    input  logic [1:0] mode,
`ifdef LED_SEQ_PAUSE_EN
    input  logic       pause,
`endif
    input  logic       done_fwd,
    input  logic       done_bwd,
    input  logic [3:0] leds_fwd,
    input  logic [3:0] leds_bwd,
    output logic       en_fwd,
    output logic       en_bwd,
    output logic [3:0] leds,
    output logic       busy,
    output logic       fin,
    output logic       err,
    output logic [7:0] pass_cnt
);

    localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [DW-1:0] DWELL_LOAD = DW'(DWELL - 1);
    localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, RUN_F, DWELL_F, RUN_B, DWELL_B} state_t;

    state_t        state, state_nxt;
    logic [1:0]    mode_q;
    logic [DW-1:0] dwell_cnt;
    logic [TW-1:0] tmo_cnt;
    logic          accept, pass_end, tmo_hit, halt, fin_set;
    logic          pause_act;
    logic          in_run, in_dwell;

`ifdef LED_SEQ_PAUSE_EN
    assign pause_act = pause;
`else
    assign pause_act = 1'b0;
`endif

    assign in_run   = (state == RUN_F) || (state == RUN_B);
    assign in_dwell = (state == DWELL_F) || (state == DWELL_B);
    assign en_fwd   = (state == RUN_F);
    assign en_bwd   = (state == RUN_B);
    assign busy     = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Stop beats everything; a completing pass beats a timeout on the same cycle.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        pass_end  = 1'b0;
        tmo_hit   = 1'b0;
        halt      = 1'b0;
        fin_set   = 1'b0;
        case (state)
            IDLE: begin
                if (start && !stop) begin
                    accept    = 1'b1;
                    state_nxt = (mode == 2'b01) ? RUN_B : RUN_F;
                end
            end
            RUN_F, RUN_B: begin
                if (stop) begin
                    halt = 1'b1;
                end else if ((state == RUN_F) ? done_fwd : done_bwd) begin
                    pass_end  = 1'b1;
                    state_nxt = (state == RUN_F) ? DWELL_F : DWELL_B;
                end else if (tmo_cnt == TMO_LAST) begin
                    tmo_hit   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            DWELL_F, DWELL_B: begin
                if (stop) begin
                    halt = 1'b1;
                end else if (!pause_act && dwell_cnt == '0) begin
                    case (mode_q)
                        2'b00:   state_nxt = RUN_F;
                        2'b01:   state_nxt = RUN_B;
                        2'b10:   state_nxt = (state == DWELL_F) ? RUN_B : RUN_F;
                        default: begin
                            if (state == DWELL_F) begin
                                state_nxt = RUN_B;
                            end else begin
                                state_nxt = IDLE;
                                fin_set   = 1'b1;
                            end
                        end
                    endcase
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (halt) state_nxt = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q    <= 2'b00;
            dwell_cnt <= '0;
            tmo_cnt   <= '0;
            leds      <= 4'b0000;
            fin       <= 1'b0;
            err       <= 1'b0;
            pass_cnt  <= 8'd0;
        end else begin
            fin <= fin_set;

            if (accept) begin
                mode_q   <= mode;
                err      <= 1'b0;
                pass_cnt <= 8'd0;
            end else begin
                if (tmo_hit) err <= 1'b1;
                if (pass_end && pass_cnt != 8'hFF) pass_cnt <= pass_cnt + 8'd1;
            end

            // Timeout count restarts at every entry into a run state.
            if (in_run && state_nxt == state) tmo_cnt <= tmo_cnt + 1'b1;
            else                              tmo_cnt <= '0;

            if (pass_end)                                        dwell_cnt <= DWELL_LOAD;
            else if (halt)                                       dwell_cnt <= '0;
            else if (in_dwell && !pause_act && dwell_cnt != '0)  dwell_cnt <= dwell_cnt - 1'b1;

            if (halt || tmo_hit)     leds <= 4'b0000;
            else if (state == RUN_F) leds <= leds_fwd;
            else if (state == RUN_B) leds <= leds_bwd;
        end
    end

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Scoreboard bench for led_seq_ctrl: stimulus queues per-cycle expectations, a negedge monitor checks them.
// Behavioral forward/backward engines walk a one-hot LED through 4 frames and raise done on the last.
module tb_led_seq_ctrl;

    logic       clk, rst_n, start, stop;
    logic [1:0] mode;
    logic       done_fwd, done_bwd;
    logic [3:0] leds_fwd, leds_bwd;
    logic       en_fwd, en_bwd, busy, fin, err;
    logic [3:0] leds;
    logic [7:0] pass_cnt;
`ifdef LED_SEQ_PAUSE_EN
    logic       pause;
`endif

    led_seq_ctrl #(.DWELL(8), .TIMEOUT(64)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .mode(mode),
`ifdef LED_SEQ_PAUSE_EN
        .pause(pause),
`endif
        .done_fwd(done_fwd), .done_bwd(done_bwd), .leds_fwd(leds_fwd), .leds_bwd(leds_bwd),
        .en_fwd(en_fwd), .en_bwd(en_bwd), .leds(leds), .busy(busy), .fin(fin), .err(err),
        .pass_cnt(pass_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Engine models: frame counter runs while enabled, restarts whenever enable is low.
    logic [1:0] ffr = 2'd0, bfr = 2'd0;
    logic       fwd_stuck = 1'b0;
    always @(posedge clk) begin
        ffr <= en_fwd ? ffr + 2'd1 : 2'd0;
        bfr <= en_bwd ? bfr + 2'd1 : 2'd0;
    end
    assign leds_fwd = 4'b0001 << ffr;
    assign leds_bwd = 4'b1000 >> bfr;
    assign done_fwd = en_fwd && (ffr == 2'd3) && !fwd_stuck;
    assign done_bwd = en_bwd && (bfr == 2'd3);

    // Vector: [16]en_fwd [15]en_bwd [14]busy [13]fin [12]err [11:8]leds [7:0]pass_cnt
    localparam logic [16:0] M_ALL   = 17'h1FFFF;
    localparam logic [16:0] M_NOLED = 17'h1F0FF;

    typedef struct {
        int          cyc;
        logic [16:0] val;
        logic [16:0] mask;
        string       name;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic logic [16:0] mk(input logic ef, input logic eb, input logic bs,
                                       input logic fn, input logic er,
                                       input logic [3:0] l, input logic [7:0] pc);
        return {ef, eb, bs, fn, er, l, pc};
    endfunction

    // Mode 00 repeat with 4-frame engine and DWELL=8: 12-cycle period, o counts cycles after start edge.
    function automatic logic [16:0] fwd_rep(input int o, input logic [3:0] prev);
        int k, r, p;
        logic [3:0] one, l;
        one = 4'b0001;
        k = (o - 1) / 12;
        r = (o - 1) % 12;
        if (r == 0)      l = (k == 0) ? prev : 4'b1000;
        else if (r <= 4) l = one << (r - 1);
        else             l = 4'b1000;
        p = (r >= 4) ? k + 1 : k;
        return mk(r < 4, 1'b0, 1'b1, 1'b0, 1'b0, l, p[7:0]);
    endfunction

    // Ping-pong first 24 cycles: forward pass, dwell, backward pass, dwell.
    function automatic logic [16:0] pp(input int o, input logic [3:0] prev);
        logic [3:0] one, eight;
        one = 4'b0001;
        eight = 4'b1000;
        if (o <= 4)  return mk(1, 0, 1, 0, 0, (o == 1) ? prev : (one << (o - 2)), 8'd0);
        if (o <= 12) return mk(0, 0, 1, 0, 0, 4'b1000, 8'd1);
        if (o <= 16) return mk(0, 1, 1, 0, 0, (o == 13) ? eight : (eight >> (o - 14)), 8'd1);
        return mk(0, 0, 1, 0, 0, 4'b0001, 8'd2);
    endfunction

    task automatic push(input string nm, input int c, input logic [16:0] v, input logic [16:0] m);
        exp_t x;
        x.cyc  = c;
        x.val  = v;
        x.mask = m;
        x.name = nm;
        sb.push_back(x);
    endtask

    task automatic go_to(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            n_checks++;
            if (e.cyc != cyc) begin
                n_fail++;
                $display("FAIL %s stale expectation cyc=%0d now=%0d", e.name, e.cyc, cyc);
            end else if ((({en_fwd, en_bwd, busy, fin, err, leds, pass_cnt} ^ e.val) & e.mask) !== 17'h0) begin
                n_fail++;
                $display("FAIL %s cyc=%0d got=%b required=%b mask=%b", e.name, cyc,
                         {en_fwd, en_bwd, busy, fin, err, leds, pass_cnt}, e.val, e.mask);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    int c;
    initial begin
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; mode = 2'b00;
`ifdef LED_SEQ_PAUSE_EN
        pause = 1'b0;
`endif
        push("reset", 1, 17'h0, M_ALL);
        push("reset", 2, 17'h0, M_ALL);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        push("idle_after_reset", 3, 17'h0, M_ALL);
        push("idle_after_reset", 4, 17'h0, M_ALL);
        go_to(4);

        // Mode 00: three passes, then stop during the third dwell.
        c = cyc; mode = 2'b00; start = 1'b1;
        for (int o = 1; o <= 36; o++) push("fwd_repeat", c + o, fwd_rep(o, 4'b0000), M_ALL);
        push("fwd_stop", c + 37, mk(0, 0, 0, 0, 0, 4'b0000, 8'd3), M_ALL);
        @(negedge clk); start = 1'b0;
        go_to(c + 36); stop = 1'b1;
        go_to(c + 37); stop = 1'b0;

        // Mode 11: one forward, one backward, fin pulse.
        c = cyc; mode = 2'b11; start = 1'b1;
        for (int o = 1; o <= 24; o++) push("pp_once", c + o, pp(o, 4'b0000), M_ALL);
        push("pp_once_fin", c + 25, mk(0, 0, 0, 1, 0, 4'b0001, 8'd2), M_ALL);
        push("pp_once_after", c + 26, mk(0, 0, 0, 0, 0, 4'b0001, 8'd2), M_ALL);
        push("pp_once_after", c + 27, mk(0, 0, 0, 0, 0, 4'b0001, 8'd2), M_ALL);
        @(negedge clk); start = 1'b0;
        go_to(c + 27);

        // Mode 10 with start while busy, then stop mid backward dwell.
        c = cyc; mode = 2'b10; start = 1'b1;
        for (int o = 1; o <= 20; o++) push("pp_repeat", c + o, pp(o, 4'b0001), M_ALL);
        push("stop_dwell_b", c + 21, mk(0, 0, 0, 0, 0, 4'b0000, 8'd2), M_ALL);
        @(negedge clk); start = 1'b0;
        go_to(c + 7); start = 1'b1; mode = 2'b00;
        go_to(c + 9); start = 1'b0;
        go_to(c + 20); stop = 1'b1;
        go_to(c + 21); stop = 1'b0;

        // Start and stop together in IDLE: stop wins, counters untouched.
        c = cyc; start = 1'b1; stop = 1'b1;
        for (int o = 1; o <= 3; o++) push("start_stop_idle", c + o, mk(0, 0, 0, 0, 0, 4'b0000, 8'd2), M_ALL);
        go_to(c + 3); start = 1'b0; stop = 1'b0;

        // Timeout: forward engine never finishes.
        c = cyc; fwd_stuck = 1'b1; mode = 2'b10; start = 1'b1;
        for (int o = 1; o <= 64; o++) push("timeout_run", c + o, mk(1, 0, 1, 0, 0, 4'b0000, 8'd0), M_NOLED);
        push("timeout_abort", c + 65, mk(0, 0, 0, 0, 1, 4'b0000, 8'd0), M_ALL);
        push("timeout_idle", c + 66, mk(0, 0, 0, 0, 1, 4'b0000, 8'd0), M_ALL);
        @(negedge clk); start = 1'b0;
        go_to(c + 66); fwd_stuck = 1'b0;
        c = cyc; mode = 2'b00; start = 1'b1;
        push("err_cleared", c + 1, mk(1, 0, 1, 0, 0, 4'b0000, 8'd0), M_ALL);
        push("err_cleared", c + 2, mk(1, 0, 1, 0, 0, 4'b0001, 8'd0), M_ALL);
        push("stop_run", c + 3, mk(0, 0, 0, 0, 0, 4'b0000, 8'd0), M_ALL);
        @(negedge clk); start = 1'b0;
        go_to(c + 2); stop = 1'b1;
        go_to(c + 3); stop = 1'b0;

        // Asynchronous reset during the second forward pass.
        c = cyc; mode = 2'b00; start = 1'b1;
        for (int o = 1; o <= 13; o++) push("pre_reset", c + o, fwd_rep(o, 4'b0000), M_ALL);
        for (int o = 14; o <= 18; o++) push("async_reset", c + o, 17'h0, M_ALL);
        @(negedge clk); start = 1'b0;
        go_to(c + 13);
        @(posedge clk);
        #1 rst_n = 1'b0;
        go_to(c + 15); rst_n = 1'b1;
        go_to(c + 18);

`ifdef LED_SEQ_PAUSE_EN
        // Pause stretches one dwell by 20 cycles, then freezes a dwell entered from a running pass.
        c = cyc; mode = 2'b00; start = 1'b1;
        for (int o = 1; o <= 5; o++) push("pause_pass1", c + o, fwd_rep(o, 4'b0000), M_ALL);
        for (int o = 6; o <= 32; o++) push("pause_dwell", c + o, mk(0, 0, 1, 0, 0, 4'b1000, 8'd1), M_ALL);
        push("pause_resume", c + 33, mk(1, 0, 1, 0, 0, 4'b1000, 8'd1), M_ALL);
        push("pause_run", c + 34, mk(1, 0, 1, 0, 0, 4'b0001, 8'd1), M_ALL);
        push("pause_run", c + 35, mk(1, 0, 1, 0, 0, 4'b0010, 8'd1), M_ALL);
        push("pause_run", c + 36, mk(1, 0, 1, 0, 0, 4'b0100, 8'd1), M_ALL);
        for (int o = 37; o <= 50; o++) push("pause_hold", c + o, mk(0, 0, 1, 0, 0, 4'b1000, 8'd2), M_ALL);
        push("pause_stop", c + 51, mk(0, 0, 0, 0, 0, 4'b0000, 8'd2), M_ALL);
        @(negedge clk); start = 1'b0;
        go_to(c + 6);  pause = 1'b1;
        go_to(c + 26); pause = 1'b0;
        go_to(c + 34); pause = 1'b1;
        go_to(c + 50); stop = 1'b1;
        go_to(c + 51); stop = 1'b0; pause = 1'b0;
`endif

        go_to(cyc + 3);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            n_checks++;
            n_fail++;
            $display("FAIL %s never checked cyc=%0d now=%0d", e.name, e.cyc, cyc);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
